lcd_frame_timing_gen: RTL

- Generates DVI pixel-domain timing (640x480@60 by default).
- Reads the captured monochrome LCD image from the frame buffer, scales it by an integer factor and centres it in the active area.
- Drives the 24-bit RGB, HSync, VSync and VDE inputs of the DVI serialiser stage directly downstream.
- Sits between the LCD capture frame buffer (1-bit read port) and the DVI output IP.

---
 rtl/lcd_frame_timing_gen_if.sv | 23 ++
 rtl/lcd_frame_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_timing_gen_if.sv
// rtl/lcd_frame_timing_gen_if.sv - frame buffer read port and DVI pixel bus
interface lcd_frame_timing_gen_if #(
    parameter int AW = 16
);
    logic          fb_rd_en;
    logic [AW-1:0] fb_addr;
    logic          fb_rd_data;
    logic [23:0]   vid_pData;
    logic          vid_pHSync;
    logic          vid_pVSync;
    logic          vid_pVDE;
    logic          frame_start;

    modport master (
        output fb_rd_en, fb_addr, vid_pData, vid_pHSync, vid_pVSync, vid_pVDE, frame_start,
        input  fb_rd_data
    );

    modport slave (
        input  fb_rd_en, fb_addr, vid_pData, vid_pHSync, vid_pVSync, vid_pVDE, frame_start,
        output fb_rd_data
    );
endinterface

// File: rtl/lcd_frame_timing_gen.sv
// rtl/lcd_frame_timing_gen.sv - DVI timing generator with integer-scaled, centred LCD image
module lcd_frame_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int SRC_W    = 256,
    parameter int SRC_H    = 160,
    parameter int SCALE    = 2,
    parameter int AW       = 16
) (
    input  logic        PixelClk,
    input  logic        pRst_n,
    input  logic        en,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    input  logic [23:0] border_color,
    lcd_frame_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_OFF   = (H_ACTIVE - SRC_W * SCALE) / 2;
    localparam int Y_OFF   = (V_ACTIVE - SRC_H * SCALE) / 2;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG0 = HW'(X_OFF);
    localparam logic [HW-1:0] H_IMG1 = HW'(X_OFF + SRC_W * SCALE);
    localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG0 = VW'(Y_OFF);
    localparam logic [VW-1:0] V_IMG1 = VW'(Y_OFF + SRC_H * SCALE);
    localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0] PH_LAST  = PW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(SRC_W);

    // Stage 0: raster counters plus source-coordinate sub-counters
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [PW-1:0] r_sx_ph, r_sy_ph;
    logic [AW-1:0] r_sx, r_row_base;

    logic          w_line_end, w_h_img, w_v_img, w_img, w_act, w_hs, w_vs, w_origin;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;

    assign w_line_end = (r_h == H_LAST);
    assign w_h_nxt    = w_line_end ? '0 : r_h + HW'(1);
    assign w_v_nxt    = !w_line_end ? r_v : ((r_v == V_LAST) ? '0 : r_v + VW'(1));
    assign w_h_img    = (r_h >= H_IMG0) && (r_h < H_IMG1);
    assign w_v_img    = (r_v >= V_IMG0) && (r_v < V_IMG1);
    assign w_img      = w_h_img && w_v_img;
    assign w_act      = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs       = (r_h >= H_HS0) && (r_h < H_HS1);
    assign w_vs       = (r_v >= V_VS0) && (r_v < V_VS1);
    assign w_origin   = (r_h == '0) && (r_v == '0);

    always_ff @(posedge PixelClk) begin
        if (!pRst_n || !en) begin
            r_h        <= '0;
            r_v        <= '0;
            r_sx       <= '0;
            r_sx_ph    <= '0;
            r_sy_ph    <= '0;
            r_row_base <= '0;
        end else begin
            r_h <= w_h_nxt;
            r_v <= w_v_nxt;
            if (w_h_nxt == H_IMG0) begin
                r_sx    <= '0;
                r_sx_ph <= '0;
            end else if (w_h_img) begin
                if (r_sx_ph == PH_LAST) begin
                    r_sx_ph <= '0;
                    r_sx    <= r_sx + AW'(1);
                end else begin
                    r_sx_ph <= r_sx_ph + PW'(1);
                end
            end
            // Row base steps by SRC_W only after SCALE repeats of a source line
            if (w_line_end) begin
                if (w_v_nxt == V_IMG0) begin
                    r_sy_ph    <= '0;
                    r_row_base <= '0;
                end else if (w_v_img) begin
                    if (r_sy_ph == PH_LAST) begin
                        r_sy_ph    <= '0;
                        r_row_base <= r_row_base + ROW_STEP;
                    end else begin
                        r_sy_ph <= r_sy_ph + PW'(1);
                    end
                end
            end
        end
    end

    // Stage 1: frame buffer request and delayed region/sync flags
    logic          r_s1_act, r_s1_img, r_s1_hs, r_s1_vs, r_s1_fs, r_rd_en;
    logic [AW-1:0] r_addr;

    always_ff @(posedge PixelClk) begin
        if (!pRst_n) begin
            r_s1_act <= 1'b0;
            r_s1_img <= 1'b0;
            r_s1_hs  <= ~HS_POL;
            r_s1_vs  <= ~VS_POL;
            r_s1_fs  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_s1_act <= en && w_act;
            r_s1_img <= en && w_img;
            r_s1_hs  <= (en && w_hs) ? HS_POL : ~HS_POL;
            r_s1_vs  <= (en && w_vs) ? VS_POL : ~VS_POL;
            r_s1_fs  <= en && w_origin;
            r_rd_en  <= en && w_img;
            if (en && w_img) begin
                r_addr <= r_row_base + r_sx;
            end
        end
    end

    // Stage 2: registered flags; read data arrives in this cycle so the colour mux follows them
    logic r_s2_act, r_s2_img, r_s2_hs, r_s2_vs, r_s2_fs;

    always_ff @(posedge PixelClk) begin
        if (!pRst_n) begin
            r_s2_act <= 1'b0;
            r_s2_img <= 1'b0;
            r_s2_hs  <= ~HS_POL;
            r_s2_vs  <= ~VS_POL;
            r_s2_fs  <= 1'b0;
        end else begin
            r_s2_act <= r_s1_act;
            r_s2_img <= r_s1_img;
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_fs  <= r_s1_fs;
        end
    end

    logic [23:0] w_pdata;

    always_comb begin
        w_pdata = 24'h000000;
        if (r_s2_img) begin
            w_pdata = bus.fb_rd_data ? fg_color : bg_color;
        end else if (r_s2_act) begin
            w_pdata = border_color;
        end
    end

    assign bus.fb_rd_en    = r_rd_en;
    assign bus.fb_addr     = r_addr;
    assign bus.vid_pData   = w_pdata;
    assign bus.vid_pHSync  = r_s2_hs;
    assign bus.vid_pVSync  = r_s2_vs;
    assign bus.vid_pVDE    = r_s2_act;
    assign bus.frame_start = r_s2_fs;
endmodule
